// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use stalls,
// multi-cycle branch flushes and the halt-drain sequence.
module hazard_ctrl #(
  parameter int REG_AW         = 3,
  parameter int NUM_SRC        = 2,
  parameter int FLUSH_CYCLES   = 1,
  parameter int LOADUSE_CYCLES = 1,
  parameter int DRAIN_CYCLES   = 3,
  parameter int ZERO_REG       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_vld,
  input  logic                      id_halt,
  input  logic [REG_AW-1:0]         ex_wreg,
  input  logic                      ex_wen,
  input  logic                      ex_memrd,
  input  logic                      ex_flush,
  input  logic [REG_AW-1:0]         mem_wreg,
  input  logic                      mem_wen,
  input  logic [REG_AW-1:0]         wb_wreg,
  input  logic                      wb_wen,
  output logic                      stall_pc,
  output logic                      stall_if_id,
  output logic                      flush_if_id,
  output logic                      bubble_id_ex,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      halted
);

  localparam int MAX_A = (FLUSH_CYCLES > LOADUSE_CYCLES) ?
                         FLUSH_CYCLES : LOADUSE_CYCLES;
  localparam int MAX_C = (MAX_A > DRAIN_CYCLES) ? MAX_A : DRAIN_CYCLES;
  localparam int CW    = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {
    S_RUN,
    S_FLUSH,
    S_STALL,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lu;

  always_comb begin
    fwd_sel = '0;
    lu      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [REG_AW-1:0] src;
      logic              v;
      logic              ex_hit;
      logic              mem_hit;
      logic              wb_hit;
      logic [1:0]        sel;
      src     = id_src[i*REG_AW +: REG_AW];
      v       = id_src_vld[i] &&
                !((ZERO_REG != 0) && (src == '0));
      ex_hit  = v && ex_wen  && (src == ex_wreg);
      mem_hit = v && mem_wen && (src == mem_wreg);
      wb_hit  = v && wb_wen  && (src == wb_wreg);
      sel     = 2'd0;
      // A load in EX has no data yet; it falls to the stall path
      if (ex_hit && ex_memrd) lu = 1'b1;
      if (ex_hit && !ex_memrd) sel = 2'd1;
      else if (mem_hit)        sel = 2'd2;
      else if (wb_hit)         sel = 2'd3;
      fwd_sel[2*i +: 2] = sel;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    priority case (1'b1)
      state_q == S_HALTED: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
      end
      state_q == S_FLUSH: begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        cnt_d        = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RUN;
      end
      ex_flush: begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = S_FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end else begin
          state_d = S_RUN;
        end
      end
      state_q == S_STALL: begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        cnt_d        = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RUN;
      end
      state_q == S_DRAIN: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        cnt_d       = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_HALTED;
      end
      lu: begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        if (LOADUSE_CYCLES > 1) begin
          state_d = S_STALL;
          cnt_d   = CW'(LOADUSE_CYCLES - 1);
        end
      end
      id_halt: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        // Trigger cycle counts as the first drain cycle
        if (DRAIN_CYCLES > 1) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES - 1);
        end else begin
          state_d = S_HALTED;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues expected outputs per cycle,
// monitor compares them on the falling edge.
module tb_hazard_ctrl;

  localparam int AW = 3;
  localparam int NS = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0]  id_src_vld;
  logic           id_halt;
  logic [AW-1:0]  ex_wreg;
  logic           ex_wen;
  logic           ex_memrd;
  logic           ex_flush;
  logic [AW-1:0]  mem_wreg;
  logic           mem_wen;
  logic [AW-1:0]  wb_wreg;
  logic           wb_wen;
  logic           stall_pc;
  logic           stall_if_id;
  logic           flush_if_id;
  logic           bubble_id_ex;
  logic [2*NS-1:0] fwd_sel;
  logic           halted;

  hazard_ctrl #(
    .REG_AW(AW),
    .NUM_SRC(NS),
    .FLUSH_CYCLES(2),
    .LOADUSE_CYCLES(2),
    .DRAIN_CYCLES(3),
    .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_src(id_src),
    .id_src_vld(id_src_vld),
    .id_halt(id_halt),
    .ex_wreg(ex_wreg),
    .ex_wen(ex_wen),
    .ex_memrd(ex_memrd),
    .ex_flush(ex_flush),
    .mem_wreg(mem_wreg),
    .mem_wen(mem_wen),
    .wb_wreg(wb_wreg),
    .wb_wen(wb_wen),
    .stall_pc(stall_pc),
    .stall_if_id(stall_if_id),
    .flush_if_id(flush_if_id),
    .bubble_id_ex(bubble_id_ex),
    .fwd_sel(fwd_sel),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [8:0] v;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [8:0] got;
  int         n_run  = 0;
  int         n_fail = 0;

  // ctl = {stall_pc, stall_if_id, flush_if_id, bubble_id_ex}
  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_STALL = 4'b1101;
  localparam logic [3:0] C_FLUSH = 4'b0011;
  localparam logic [3:0] C_DRAIN = 4'b1010;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      got = {stall_pc, stall_if_id, flush_if_id, bubble_id_ex,
             fwd_sel, halted};
      n_run++;
      if (got !== mon_e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", mon_e.nm, got, mon_e.v);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_src     = '0;
    id_src_vld = '0;
    id_halt    = 1'b0;
    ex_wreg    = '0;
    ex_wen     = 1'b0;
    ex_memrd   = 1'b0;
    ex_flush   = 1'b0;
    mem_wreg   = '0;
    mem_wen    = 1'b0;
    wb_wreg    = '0;
    wb_wen     = 1'b0;
  endtask

  task automatic lu_in();
    ex_memrd   = 1'b1;
    ex_wen     = 1'b1;
    ex_wreg    = 3'd5;
    id_src     = {3'd5, 3'd0};
    id_src_vld = 2'b10;
  endtask

  task automatic push(string nm, logic [3:0] ctl, logic [3:0] fw,
                      logic h);
    exp_t e;
    e.nm = nm;
    e.v  = {ctl, fw, h};
    q.push_back(e);
  endtask

  task automatic vec_idle(string nm);
    cyc(); idle();
    push(nm, C_NONE, 4'b0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc(); push("reset", C_NONE, 4'b0000, 1'b0);
    cyc(); rst = 1'b0;
    push("idle", C_NONE, 4'b0000, 1'b0);

    // forwarding
    cyc(); idle();
    id_src = {3'd0, 3'd3}; id_src_vld = 2'b01;
    ex_wen = 1; ex_wreg = 3; mem_wen = 1; mem_wreg = 3;
    push("fwd_ex", C_NONE, 4'b0001, 1'b0);
    cyc(); ex_wen = 0;
    push("fwd_mem", C_NONE, 4'b0010, 1'b0);
    cyc(); mem_wen = 0; wb_wen = 1; wb_wreg = 3;
    push("fwd_wb", C_NONE, 4'b0011, 1'b0);
    cyc(); idle();
    id_src = '0; id_src_vld = 2'b11;
    ex_wen = 1; mem_wen = 1; wb_wen = 1; ex_memrd = 1;
    push("fwd_zero", C_NONE, 4'b0000, 1'b0);
    cyc(); idle();
    id_src = {3'd4, 3'd1}; id_src_vld = 2'b10;
    mem_wen = 1; mem_wreg = 4; ex_wreg = 4;
    push("fwd_src1_mem", C_NONE, 4'b1000, 1'b0);
    cyc(); idle();
    id_src = {3'd6, 3'd2}; id_src_vld = 2'b11;
    ex_wen = 1; ex_wreg = 2; wb_wen = 1; wb_wreg = 6;
    push("fwd_both", C_NONE, 4'b1101, 1'b0);

    // load-use, two cycles
    cyc(); idle(); lu_in();
    push("lu_c0", C_STALL, 4'b0000, 1'b0);
    cyc(); idle();
    push("lu_c1", C_STALL, 4'b0000, 1'b0);
    vec_idle("lu_done");

    // branch flush, two cycles
    cyc(); idle(); ex_flush = 1;
    push("fl_c0", C_FLUSH, 4'b0000, 1'b0);
    cyc(); idle();
    push("fl_c1", C_FLUSH, 4'b0000, 1'b0);
    vec_idle("fl_done");

    // flush beats load-use
    cyc(); idle(); lu_in(); ex_flush = 1;
    push("fl_lu_c0", C_FLUSH, 4'b0000, 1'b0);
    cyc(); idle();
    push("fl_lu_c1", C_FLUSH, 4'b0000, 1'b0);
    vec_idle("fl_lu_done");

    // halt drain
    cyc(); idle(); id_halt = 1;
    push("halt_c0", C_DRAIN, 4'b0000, 1'b0);
    cyc(); idle();
    push("halt_c1", C_DRAIN, 4'b0000, 1'b0);
    cyc();
    push("halt_c2", C_DRAIN, 4'b0000, 1'b0);
    cyc();
    push("halt_c3", C_DRAIN, 4'b0000, 1'b1);
    cyc();
    push("halt_hold", C_DRAIN, 4'b0000, 1'b1);
    cyc(); lu_in(); ex_flush = 1;
    push("halt_hold_fl", C_DRAIN, 4'b0000, 1'b1);
    cyc(); idle(); rst = 1'b1;
    push("rst_halted", C_NONE, 4'b0000, 1'b0);
    cyc(); rst = 1'b0;
    push("post_rst1", C_NONE, 4'b0000, 1'b0);

    // squash halt with older branch
    cyc(); idle(); id_halt = 1;
    push("sq_c0", C_DRAIN, 4'b0000, 1'b0);
    cyc(); idle(); ex_flush = 1;
    push("sq_c1", C_FLUSH, 4'b0000, 1'b0);
    cyc(); idle();
    push("sq_c2", C_FLUSH, 4'b0000, 1'b0);
    vec_idle("sq_done");
    vec_idle("sq_no_halt");

    // async reset while stalled
    cyc(); idle(); lu_in();
    push("lu2_c0", C_STALL, 4'b0000, 1'b0);
    cyc(); idle(); rst = 1'b1;
    push("rst_stall", C_NONE, 4'b0000, 1'b0);
    cyc(); rst = 1'b0;
    push("post_rst2", C_NONE, 4'b0000, 1'b0);

    // branch during stall overrides
    cyc(); idle(); lu_in();
    push("lu3_c0", C_STALL, 4'b0000, 1'b0);
    cyc(); idle(); ex_flush = 1;
    push("lu3_fl", C_FLUSH, 4'b0000, 1'b0);
    cyc(); idle();
    push("lu3_fl_c1", C_FLUSH, 4'b0000, 1'b0);
    vec_idle("lu3_done");

    // load-use beats halt
    cyc(); idle(); lu_in(); id_halt = 1;
    push("lu_halt_c0", C_STALL, 4'b0000, 1'b0);
    cyc(); idle();
    push("lu_halt_c1", C_STALL, 4'b0000, 1'b0);
    vec_idle("lu_halt_done");

    cyc(); cyc();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
